i2c_codec_target: RTL

- Synthesizable I2C target (responder) that emulates the CODEC's register file. It is the far end of the I2C bus driven by the I2C master in the codec controller unit.
- Used in closed-loop simulation and FPGA self-test of the codec controller path, with no physical CODEC attached.
- Holds 2^ADDR_W 8-bit registers and supports byte writes, auto-increment bursts and reads via repeated START.
- Reports every committed write on a local strobe port.

---
 rtl/i2c_codec_target_pkg.sv | 22 ++
 rtl/i2c_line_cond.sv | 72 +++++++
 rtl/i2c_codec_target.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_target_pkg.sv
// Shared types and constants for the I2C CODEC register-file target.
package i2c_codec_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;
  localparam int   FILT_LEN      = 3;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional stable-sample filter
// (I2C_CODEC_TARGET_GLITCH_FILTER_EN), and SCL edge / START / STOP pulses.
module i2c_line_cond
  import i2c_codec_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0] raw;
  logic [1:0] line;
  logic [1:0] prev_reg;

  assign raw = {sda_i, scl_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= raw[gi];
        sync_reg <= meta_reg;
      end
    end

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] hist_reg;
    logic                filt_reg;
    logic [FILT_LEN-1:0] window;

    // Output follows the line only once the whole window agrees.
    assign window   = {hist_reg, sync_reg};
    assign line[gi] = (&window) ? 1'b1 : ((~|window) ? 1'b0 : filt_reg);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hist_reg <= '1;
        filt_reg <= 1'b1;
      end else begin
        hist_reg <= {hist_reg[FILT_LEN-3:0], sync_reg};
        filt_reg <= line[gi];
      end
    end
`else
    assign line[gi] = sync_reg;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= 2'b11;
    else       prev_reg <= line;
  end

  assign sda      = line[1];
  assign scl_rise = line[0] & ~prev_reg[0];
  assign scl_fall = ~line[0] & prev_reg[0];
  assign start    = line[0] & prev_reg[0] & prev_reg[1] & ~line[1];
  assign stop     = line[0] & prev_reg[0] & ~prev_reg[1] & line[1];

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target emulating the CODEC register file: byte/burst writes, reads via
// repeated START. Optional input glitch filter: I2C_CODEC_TARGET_GLITCH_FILTER_EN.
module i2c_codec_target
  import i2c_codec_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h1A,
  parameter int         ADDR_W        = 8,
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       target_busy
);

  logic sda_line, scl_rise, scl_fall, start_pulse, stop_pulse;

  i2c_line_cond u_line_cond (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (i2c_scl_i),
    .sda_i    (i2c_sda_i),
    .sda      (sda_line),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_pulse),
    .stop     (stop_pulse)
  );

  i2c_tgt_state_t    state_reg;
  logic [3:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [ADDR_W-1:0] pointer_reg;
  logic              rw_reg;
  logic              sda_t_reg;
  logic              busy_reg;
  logic              wr_valid_reg;
  logic [7:0]        wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic [7:0]        regs_reg [2**ADDR_W];
  logic [7:0]        rd_data;

  assign rd_data = regs_reg[pointer_reg];

  // The register file is written from the committed-byte outputs, one clk later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_reg[i] <= REG_RESET_VAL;
    end else if (wr_valid_reg) begin
      regs_reg[wr_addr_reg[ADDR_W-1:0]] <= wr_data_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      pointer_reg  <= '0;
      rw_reg       <= 1'b0;
      sda_t_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= 8'h00;
      wr_data_reg  <= 8'h00;
    end else begin
      wr_valid_reg <= 1'b0;
      if (start_pulse) begin
        state_reg   <= ST_DEV_ADDR;
        bit_cnt_reg <= 4'd0;
        sda_t_reg   <= 1'b1;
      end else if (stop_pulse) begin
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 4'd0;
        sda_t_reg   <= 1'b1;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_WAIT_STOP: sda_t_reg <= 1'b1;
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_line};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == 4'(BITS_PER_BYTE)) begin
              bit_cnt_reg <= 4'd0;
              if (state_reg == ST_DEV_ADDR) begin
                if (shift_reg[7:1] == DEV_ADDR) begin
                  sda_t_reg <= ACK;
                  busy_reg  <= 1'b1;
                  rw_reg    <= shift_reg[0];
                  state_reg <= ST_DEV_ACK;
                end else begin
                  state_reg <= ST_WAIT_STOP;
                end
              end else if (state_reg == ST_REG_ADDR) begin
                pointer_reg <= shift_reg[ADDR_W-1:0];
                sda_t_reg   <= ACK;
                state_reg   <= ST_REG_ACK;
              end else begin
                wr_valid_reg <= 1'b1;
                wr_addr_reg  <= 8'(pointer_reg);
                wr_data_reg  <= shift_reg;
                pointer_reg  <= pointer_reg + ADDR_W'(1);
                sda_t_reg    <= ACK;
                state_reg    <= ST_WR_ACK;
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              if (rw_reg) begin
                // First read bit goes out on the same fall that ends the ACK.
                shift_reg   <= rd_data;
                sda_t_reg   <= rd_data[7];
                bit_cnt_reg <= 4'd1;
                state_reg   <= ST_RD_DATA;
              end else begin
                sda_t_reg   <= 1'b1;
                bit_cnt_reg <= 4'd0;
                state_reg   <= ST_REG_ADDR;
              end
            end
          end
          ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              sda_t_reg   <= 1'b1;
              bit_cnt_reg <= 4'd0;
              state_reg   <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_reg == 4'(BITS_PER_BYTE)) begin
                sda_t_reg <= 1'b1;
                state_reg <= ST_RD_ACK;
              end else begin
                sda_t_reg   <= shift_reg[6];
                shift_reg   <= {shift_reg[6:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_line == NACK) begin
                state_reg <= ST_WAIT_STOP;
                busy_reg  <= 1'b0;
              end else begin
                pointer_reg <= pointer_reg + ADDR_W'(1);
              end
            end else if (scl_fall) begin
              // Only reachable after a master ACK; pointer is already advanced.
              shift_reg   <= rd_data;
              sda_t_reg   <= rd_data[7];
              bit_cnt_reg <= 4'd1;
              state_reg   <= ST_RD_DATA;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            sda_t_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign i2c_sda_o    = 1'b0;
  assign i2c_sda_t    = sda_t_reg;
  assign reg_wr_valid = wr_valid_reg;
  assign reg_wr_addr  = wr_addr_reg;
  assign reg_wr_data  = wr_data_reg;
  assign target_busy  = busy_reg;

endmodule
